// File: rtl/misao_mem_pkg.sv
// Shared types for the MISA-O external memory arbiter.
// Transfer sizes, arbiter states and the bus address width.
package misao_mem_pkg;

   localparam int MEM_AW = 15;

   typedef enum logic [1:0] {
      SZ_UL   = 2'b00,
      SZ_LK8  = 2'b01,
      SZ_LK16 = 2'b10
   } xmem_size_t;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DLO,
      DHI,
      DONE_F,
      DONE_D
   } arb_state_t;

   // The unused encoding 2'b11 behaves as a byte access.
   function automatic xmem_size_t decode_size(input logic [1:0] sz);
      case (sz)
         2'b00:   return SZ_UL;
         2'b10:   return SZ_LK16;
         default: return SZ_LK8;
      endcase
   endfunction

endpackage

// File: rtl/misao_beat_timer.sv
// Wait-state counter: one bus beat lasts WAIT_STATES+1 cycles.
// last_next looks one cycle ahead so write strobes can be registered.
module misao_beat_timer #(
   parameter int WAIT_STATES = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic beat_last,
   output logic last_next
);

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   logic [3:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= WS;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 4'd1;
      end
   end

   assign beat_last = (cnt_q == '0);
   assign last_next = load ? (WS == '0) : (cnt_q == 4'd1);

endmodule

// File: rtl/misao_mem_arbiter.sv
// Shares the 8-bit external bus between instruction fetch and XMEM.
// XMEM accesses are split into byte beats; words are little-endian.
module misao_mem_arbiter
   import misao_mem_pkg::*;
#(
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [MEM_AW-1:0] fetch_addr,
   output logic              fetch_ack,
   output logic [7:0]        fetch_rdata,
   input  logic              dat_req,
   input  logic              dat_we,
   input  logic [1:0]        dat_size,
   input  logic [MEM_AW-1:0] dat_addr,
   input  logic [15:0]       dat_wdata,
   output logic              dat_ack,
   output logic [15:0]       dat_rdata,
   output logic              mem_enable_read,
   output logic              mem_enable_write,
   output logic              mem_rw,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [7:0]        mem_data_out,
   input  logic [7:0]        mem_data_in
);

   arb_state_t        state_q, state_d;
   logic              enter;
   logic [MEM_AW-1:0] addr_q;
   xmem_size_t        size_q;
   logic              we_q;
   logic [7:0]        whi_q;
   logic [7:0]        lo_q;
   logic              beat_last, last_next;
   logic              in_beat_d, rw_d;
   logic [MEM_AW-1:0] baddr_d;
   logic [7:0]        bdata_d;

   misao_beat_timer #(
      .WAIT_STATES(WAIT_STATES)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (enter),
      .beat_last(beat_last),
      .last_next(last_next)
   );

   always_comb begin
      state_d = state_q;
      enter   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (dat_req) begin
               state_d = DLO;
               enter   = 1'b1;
            end else if (fetch_req) begin
               state_d = FETCH;
               enter   = 1'b1;
            end
         end
         FETCH: if (beat_last) state_d = DONE_F;
         DLO: begin
            if (beat_last) begin
               if (size_q == SZ_LK16) begin
                  state_d = DHI;
                  enter   = 1'b1;
               end else begin
                  state_d = DONE_D;
               end
            end
         end
         DHI: if (beat_last) state_d = DONE_D;
         default: state_d = IDLE;
      endcase
   end

   // Next-beat address/data; held for the whole beat once entered.
   always_comb begin
      baddr_d = mem_addr;
      rw_d    = mem_rw;
      bdata_d = mem_data_out;
      unique case (1'b1)
         enter && state_d == FETCH: begin
            baddr_d = fetch_addr;
            rw_d    = 1'b0;
         end
         enter && state_d == DLO: begin
            baddr_d = dat_addr;
            rw_d    = dat_we;
            bdata_d = (decode_size(dat_size) == SZ_UL)
                    ? {4'h0, dat_wdata[3:0]}
                    : dat_wdata[7:0];
         end
         enter && state_d == DHI: begin
            baddr_d = addr_q + 15'd1;
            rw_d    = we_q;
            bdata_d = whi_q;
         end
         default: ;
      endcase
   end

   assign in_beat_d = (state_d == FETCH) || (state_d == DLO)
                   || (state_d == DHI);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= IDLE;
         addr_q           <= '0;
         size_q           <= SZ_UL;
         we_q             <= 1'b0;
         whi_q            <= '0;
         lo_q             <= '0;
         fetch_rdata      <= '0;
         dat_rdata        <= '0;
         mem_addr         <= '0;
         mem_rw           <= 1'b0;
         mem_enable_read  <= 1'b0;
         mem_enable_write <= 1'b0;
         mem_data_out     <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && state_d == DLO) begin
            addr_q <= dat_addr;
            size_q <= decode_size(dat_size);
            we_q   <= dat_we;
            whi_q  <= dat_wdata[15:8];
         end
         if (enter) begin
            mem_addr     <= baddr_d;
            mem_data_out <= bdata_d;
         end
         mem_rw           <= in_beat_d & rw_d;
         mem_enable_read  <= in_beat_d & ~rw_d;
         mem_enable_write <= in_beat_d & rw_d & last_next;
         if (beat_last && !mem_rw) begin
            unique case (state_q)
               FETCH: fetch_rdata <= mem_data_in;
               DLO: begin
                  lo_q <= mem_data_in;
                  if (size_q == SZ_UL)
                     dat_rdata <= {12'h0, mem_data_in[3:0]};
                  else if (size_q == SZ_LK8)
                     dat_rdata <= {8'h0, mem_data_in};
               end
               DHI: dat_rdata <= {mem_data_in, lo_q};
               default: ;
            endcase
         end
      end
   end

   assign fetch_ack = (state_q == DONE_F);
   assign dat_ack   = (state_q == DONE_D);

endmodule

// File: tb/tb_misao_mem_arbiter.sv
// Bench for misao_mem_arbiter: instance 0 with no wait states,
// instance 1 with three, each against its own memory and model.
module tb_misao_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst[2];
   logic        fetch_req[2];
   logic [14:0] fetch_addr[2];
   logic        fetch_ack[2];
   logic [7:0]  fetch_rdata[2];
   logic        dat_req[2];
   logic        dat_we[2];
   logic [1:0]  dat_size[2];
   logic [14:0] dat_addr[2];
   logic [15:0] dat_wdata[2];
   logic        dat_ack[2];
   logic [15:0] dat_rdata[2];
   logic        mem_enable_read[2];
   logic        mem_enable_write[2];
   logic        mem_rw[2];
   logic [14:0] mem_addr[2];
   logic [7:0]  mem_data_out[2];
   logic [7:0]  mem_data_in[2];
   logic [7:0]  mem[2][32768];

   function automatic logic [7:0] init_byte(input int a);
      if (a == 5) return 8'hA3;
      if (a == 'h81) return 8'h5B;
      return 8'(a * 37 + (a >> 7));
   endfunction

   for (genvar k = 0; k < 2; k++) begin : g_dut
      misao_mem_arbiter #(
         .WAIT_STATES(3 * k)
      ) u_dut (
         .clk             (clk),
         .rst             (rst[k]),
         .fetch_req       (fetch_req[k]),
         .fetch_addr      (fetch_addr[k]),
         .fetch_ack       (fetch_ack[k]),
         .fetch_rdata     (fetch_rdata[k]),
         .dat_req         (dat_req[k]),
         .dat_we          (dat_we[k]),
         .dat_size        (dat_size[k]),
         .dat_addr        (dat_addr[k]),
         .dat_wdata       (dat_wdata[k]),
         .dat_ack         (dat_ack[k]),
         .dat_rdata       (dat_rdata[k]),
         .mem_enable_read (mem_enable_read[k]),
         .mem_enable_write(mem_enable_write[k]),
         .mem_rw          (mem_rw[k]),
         .mem_addr        (mem_addr[k]),
         .mem_data_out    (mem_data_out[k]),
         .mem_data_in     (mem_data_in[k])
      );
      assign mem_data_in[k] = mem[k][mem_addr[k]];
   end

   // Memory device: writes on the rising edge while the strobe is high.
   initial begin
      for (int k = 0; k < 2; k++)
         for (int a = 0; a < 32768; a++)
            mem[k][a] = init_byte(a);
      forever begin
         @(posedge clk);
         for (int k = 0; k < 2; k++)
            if (mem_enable_write[k])
               mem[k][mem_addr[k]] <= mem_data_out[k];
      end
   end

   int vectors = 0;
   int errors = 0;

   // Transaction-level model state per instance.
   bit          m_act[2];
   int          m_g[2];
   int          m_nb[2];
   bit          m_f[2];
   bit          m_rw[2];
   logic [14:0] m_ba[2][2];
   logic [7:0]  m_bd[2][2];
   logic [15:0] m_val[2];
   logic [14:0] m_last[2];
   logic [7:0]  e_frd[2];
   logic [15:0] e_drd[2];
   logic [7:0]  exp_mem[2][32768];
   bit          fseen[2];
   bit          dseen[2];
   int          wstb[2];
   int          rstb[2];

   task automatic chk(input string nm, input int k,
                      input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] cyc %0d: got %0h, expected %0h",
                  nm, k, cyc, act, exp);
      end
   endtask

   task automatic grant(input int k);
      logic [14:0] a;
      logic [15:0] wd;
      logic [7:0]  b0, b1;
      m_act[k] = 1'b1;
      m_g[k]   = cyc;
      if (dat_req[k]) begin
         a  = dat_addr[k];
         wd = dat_wdata[k];
         b0 = exp_mem[k][a];
         b1 = exp_mem[k][a + 15'd1];
         m_f[k]     = 1'b0;
         m_rw[k]    = dat_we[k];
         m_ba[k][0] = a;
         m_ba[k][1] = a + 15'd1;
         m_nb[k]    = (dat_size[k] == 2'b10) ? 2 : 1;
         case (dat_size[k])
            2'b00: begin
               m_bd[k][0] = {4'h0, wd[3:0]};
               m_val[k]   = {12'h0, b0[3:0]};
            end
            2'b10: begin
               m_bd[k][0] = wd[7:0];
               m_bd[k][1] = wd[15:8];
               m_val[k]   = {b1, b0};
            end
            default: begin
               m_bd[k][0] = wd[7:0];
               m_val[k]   = {8'h0, b0};
            end
         endcase
      end else begin
         a = fetch_addr[k];
         m_f[k]     = 1'b1;
         m_rw[k]    = 1'b0;
         m_nb[k]    = 1;
         m_ba[k][0] = a;
         m_val[k]   = {8'h0, exp_mem[k][a]};
      end
   endtask

   // Called once per cycle at the falling edge; checks every output.
   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         logic efa, eda, erd, ewr, erw;
         int   off, b, w, len;
         len = 3 * k + 1;
         efa = 0; eda = 0; erd = 0; ewr = 0; erw = 0;
         if (!rst[k]) begin
            m_act[k]  = 1'b0;
            m_last[k] = '0;
            e_frd[k]  = '0;
            e_drd[k]  = '0;
            chk("mem_data_out_rst", k, 32'(mem_data_out[k]), 0);
         end else begin
            if (!m_act[k] && (dat_req[k] || fetch_req[k]))
               grant(k);
            if (m_act[k]) begin
               off = cyc - m_g[k];
               if (off >= 1 && off <= m_nb[k] * len) begin
                  b = (off - 1) / len;
                  w = (off - 1) % len;
                  m_last[k] = m_ba[k][b];
                  erw = m_rw[k];
                  erd = !m_rw[k];
                  ewr = m_rw[k] && (w == len - 1);
                  if (m_rw[k])
                     chk("mem_data_out", k, 32'(mem_data_out[k]),
                         32'(m_bd[k][b]));
                  if (ewr) exp_mem[k][m_ba[k][b]] = m_bd[k][b];
               end else if (off > m_nb[k] * len) begin
                  m_act[k] = 1'b0;
                  if (m_f[k]) begin
                     efa = 1;
                     e_frd[k] = m_val[k][7:0];
                  end else begin
                     eda = 1;
                     if (!m_rw[k]) e_drd[k] = m_val[k];
                  end
               end
            end
         end
         chk("fetch_ack", k, 32'(fetch_ack[k]), 32'(efa));
         chk("dat_ack", k, 32'(dat_ack[k]), 32'(eda));
         chk("fetch_rdata", k, 32'(fetch_rdata[k]), 32'(e_frd[k]));
         chk("dat_rdata", k, 32'(dat_rdata[k]), 32'(e_drd[k]));
         chk("mem_enable_read", k, 32'(mem_enable_read[k]), 32'(erd));
         chk("mem_enable_write", k, 32'(mem_enable_write[k]), 32'(ewr));
         chk("mem_rw", k, 32'(mem_rw[k]), 32'(erw));
         chk("mem_addr", k, 32'(mem_addr[k]), 32'(m_last[k]));
         fseen[k] = fetch_ack[k];
         dseen[k] = dat_ack[k];
         if (mem_enable_write[k] === 1'b1) wstb[k]++;
         if (mem_enable_read[k] === 1'b1) rstb[k]++;
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   // One request on instance k; returns latency and read data.
   task automatic xact(input int k, input bit isdat, input bit we,
                       input logic [1:0] sz, input logic [14:0] a,
                       input logic [15:0] wd,
                       output int lat, output logic [15:0] rd);
      int t0;
      bit got;
      if (isdat) begin
         dat_req[k]   = 1'b1;
         dat_we[k]    = we;
         dat_size[k]  = sz;
         dat_addr[k]  = a;
         dat_wdata[k] = wd;
      end else begin
         fetch_req[k]  = 1'b1;
         fetch_addr[k] = a;
      end
      t0 = cyc;
      got = 0;
      lat = -1;
      rd = '0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         model_step();
         if (isdat ? dat_ack[k] : fetch_ack[k]) begin
            got = 1;
            lat = cyc - t0;
            rd = isdat ? dat_rdata[k] : {8'h0, fetch_rdata[k]};
         end
         @(posedge clk);
         #1;
      end
      fetch_req[k] = 1'b0;
      dat_req[k] = 1'b0;
      chk("ack_seen", k, 32'(got), 1);
   endtask

   function automatic logic [14:0] rand_addr();
      case ($urandom_range(0, 3))
         0:       return 15'h7FFF;
         1:       return 15'($urandom_range(0, 15));
         default: return 15'($urandom);
      endcase
   endfunction

   initial begin
      int lat, t0, dc, fc, nbad, w0, r0;
      logic [15:0] rd, drd;
      logic [7:0]  frd;
      bit gd, gf;

      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b0;
         fetch_req[k] = 1'b0;
         fetch_addr[k] = '0;
         dat_req[k] = 1'b0;
         dat_we[k] = 1'b0;
         dat_size[k] = '0;
         dat_addr[k] = '0;
         dat_wdata[k] = '0;
         m_act[k] = 1'b0;
         m_last[k] = '0;
         e_frd[k] = '0;
         e_drd[k] = '0;
         wstb[k] = 0;
         rstb[k] = 0;
         for (int a = 0; a < 32768; a++)
            exp_mem[k][a] = init_byte(a);
      end

      repeat (3) step();
      chk("reset_mem_addr", 0, 32'(mem_addr[0]), 0);
      chk("reset_dat_rdata", 1, 32'(dat_rdata[1]), 0);
      rst[0] = 1'b1;
      rst[1] = 1'b1;
      repeat (2) step();

      r0 = rstb[0];
      xact(0, 0, 0, 2'b00, 15'h0005, 16'h0, lat, rd);
      chk("fetch5_lat", 0, lat, 2);
      chk("fetch5_data", 0, 32'(rd), 32'hA3);
      chk("fetch5_beats", 0, rstb[0] - r0, 1);

      xact(0, 1, 1, 2'b00, 15'h0080, 16'hFFF5, lat, rd);
      chk("ul_store_mem", 0, 32'(mem[0][15'h80]), 32'h05);
      xact(0, 1, 0, 2'b00, 15'h0080, 16'h0, lat, rd);
      chk("ul_load_data", 0, 32'(rd), 32'h0005);
      chk("ul_load_lat", 0, lat, 2);

      xact(0, 1, 1, 2'b10, 15'h0090, 16'h1234, lat, rd);
      chk("w_store_lo", 0, 32'(mem[0][15'h90]), 32'h34);
      chk("w_store_hi", 0, 32'(mem[0][15'h91]), 32'h12);
      xact(0, 1, 0, 2'b10, 15'h0090, 16'h0, lat, rd);
      chk("w_load_data", 0, 32'(rd), 32'h1234);
      chk("w_load_lat", 0, lat, 3);

      // Simultaneous requests: the data port must win.
      dat_req[0] = 1'b1;
      dat_we[0] = 1'b0;
      dat_size[0] = 2'b01;
      dat_addr[0] = 15'h0081;
      fetch_req[0] = 1'b1;
      fetch_addr[0] = 15'h0010;
      t0 = cyc;
      gd = 0; gf = 0; dc = -1; fc = -1;
      drd = '0; frd = '0;
      for (int i = 0; i < 50 && !gf; i++) begin
         @(negedge clk);
         model_step();
         if (dat_ack[0]) begin
            gd = 1; dc = cyc; drd = dat_rdata[0];
         end
         if (fetch_ack[0]) begin
            gf = 1; fc = cyc; frd = fetch_rdata[0];
         end
         @(posedge clk);
         #1;
         if (gd) dat_req[0] = 1'b0;
      end
      fetch_req[0] = 1'b0;
      dat_req[0] = 1'b0;
      chk("both_dat_lat", 0, dc - t0, 2);
      chk("both_dat_data", 0, 32'(drd), 32'h005B);
      chk("both_fetch_lat", 0, fc - t0, 5);
      chk("both_fetch_data", 0, 32'(frd), 32'(init_byte(16)));

      xact(0, 1, 1, 2'b10, 15'h7FFF, 16'hC3D4, lat, rd);
      chk("wrap_lat", 0, lat, 3);
      chk("wrap_lo", 0, 32'(mem[0][15'h7FFF]), 32'hD4);
      chk("wrap_hi", 0, 32'(mem[0][15'h0000]), 32'hC3);

      w0 = wstb[1];
      xact(1, 1, 1, 2'b10, 15'h7FFF, 16'hC3D4, lat, rd);
      chk("ws3_w_lat", 1, lat, 9);
      chk("ws3_strobes", 1, wstb[1] - w0, 2);
      chk("ws3_lo", 1, 32'(mem[1][15'h7FFF]), 32'hD4);
      chk("ws3_hi", 1, 32'(mem[1][15'h0000]), 32'hC3);
      xact(1, 1, 0, 2'b10, 15'h7FFF, 16'h0, lat, rd);
      chk("ws3_load", 1, 32'(rd), 32'hC3D4);
      xact(1, 0, 0, 2'b00, 15'h0005, 16'h0, lat, rd);
      chk("ws3_f_lat", 1, lat, 5);

      // Reset in the high beat of a word store.
      dat_req[0] = 1'b1;
      dat_we[0] = 1'b1;
      dat_size[0] = 2'b10;
      dat_addr[0] = 15'h00A0;
      dat_wdata[0] = 16'hBEEF;
      step();
      step();
      rst[0] = 1'b0;
      dat_req[0] = 1'b0;
      @(negedge clk);
      model_step();
      chk("abort_ack", 0, 32'(dat_ack[0]), 0);
      chk("abort_we", 0, 32'(mem_enable_write[0]), 0);
      chk("abort_addr", 0, 32'(mem_addr[0]), 0);
      @(posedge clk);
      #1;
      step();
      rst[0] = 1'b1;
      step();
      chk("abort_lo", 0, 32'(mem[0][15'h00A0]), 32'hEF);
      chk("abort_hi", 0, 32'(mem[0][15'h00A1]),
          32'(init_byte('hA1)));
      xact(0, 0, 0, 2'b00, 15'h0005, 16'h0, lat, rd);
      chk("post_rst_lat", 0, lat, 2);
      chk("post_rst_data", 0, 32'(rd), 32'hA3);

      // Random traffic on both instances with occasional resets.
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         model_step();
         @(posedge clk);
         #1;
         for (int k = 0; k < 2; k++) begin
            if (!rst[k]) begin
               if ($urandom_range(0, 2) == 0) rst[k] = 1'b1;
            end else if ($urandom_range(0, 799) == 0) begin
               rst[k] = 1'b0;
               fetch_req[k] = 1'b0;
               dat_req[k] = 1'b0;
            end else begin
               if (fetch_req[k] && fseen[k]) begin
                  fetch_req[k] = 1'b0;
               end else if (!fetch_req[k]
                            && $urandom_range(0, 2) == 0) begin
                  fetch_req[k] = 1'b1;
                  fetch_addr[k] = rand_addr();
               end
               if (dat_req[k] && dseen[k]) begin
                  dat_req[k] = 1'b0;
               end else if (!dat_req[k]
                            && $urandom_range(0, 2) == 0) begin
                  dat_req[k] = 1'b1;
                  dat_we[k] = 1'($urandom);
                  dat_size[k] = 2'($urandom);
                  dat_addr[k] = rand_addr();
                  dat_wdata[k] = 16'($urandom);
               end
            end
         end
      end
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1;
         fetch_req[k] = 1'b0;
         dat_req[k] = 1'b0;
      end
      repeat (30) step();

      for (int k = 0; k < 2; k++) begin
         nbad = 0;
         for (int a = 0; a < 32768; a++)
            if (mem[k][a] !== exp_mem[k][a]) nbad++;
         chk("mem_image", k, nbad, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule
